forwarding_hazard_unit: RTL and testbench

FORWARDING_HAZARD_UNIT -- requirements
Module: forwarding_hazard_unit

---
 rtl/forwarding_hazard_unit.sv | 153 +++++++++++++++
 tb/tb_forwarding_hazard_unit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/forwarding_hazard_unit.sv
// Forwarding and load-use hazard unit for an in-order 5-stage pipeline.
// Keeps shadow copies of the ID/EX, EX/MEM and MEM/WB register-usage fields
// and derives the EX operand mux selects, the ID write-through bypass and
// the load-use stall from them.
//
// Ports
//   clk, reset_n    : clock, asynchronous active-low reset
//   id_valid        : ID slot holds a real instruction
//   id_rs, id_use   : ID source addresses (source k at [k*REG_AW +: REG_AW]) and read flags
//   id_rd           : ID destination address
//   id_regwrite     : ID instruction writes id_rd
//   id_memread      : ID instruction is a load
//   flush           : squash the ID instruction
//   ext_stall       : freeze the whole pipeline
//   forward_sel     : EX mux select per source (00 regfile, 10 EX/MEM, 01 MEM/WB), combinational
//   wb_bypass       : ID source k takes WB write data, combinational
//   stall           : load-use stall, combinational
//   stall_count     : saturating count of stall cycles, registered
module forwarding_hazard_unit #(
   parameter int unsigned REG_AW  = 5,
   parameter int unsigned NUM_SRC = 2,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      id_valid,
   input  logic [NUM_SRC*REG_AW-1:0] id_rs,
   input  logic [NUM_SRC-1:0]        id_use,
   input  logic [REG_AW-1:0]         id_rd,
   input  logic                      id_regwrite,
   input  logic                      id_memread,
   input  logic                      flush,
   input  logic                      ext_stall,
   output logic [2*NUM_SRC-1:0]      forward_sel,
   output logic [NUM_SRC-1:0]        wb_bypass,
   output logic                      stall,
   output logic [CNT_W-1:0]          stall_count
);

   localparam int unsigned    RS_W    = NUM_SRC * REG_AW;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [RS_W-1:0]    idex_rs_q, idex_rs_d;
   logic [NUM_SRC-1:0] idex_use_q, idex_use_d;
   logic [REG_AW-1:0]  idex_rd_q, idex_rd_d;
   logic               idex_regwrite_q, idex_regwrite_d;
   logic               idex_memread_q, idex_memread_d;
   logic [REG_AW-1:0]  exmem_rd_q, exmem_rd_d;
   logic               exmem_regwrite_q, exmem_regwrite_d;
   logic               exmem_memread_q, exmem_memread_d;
   logic [REG_AW-1:0]  memwb_rd_q, memwb_rd_d;
   logic               memwb_regwrite_q, memwb_regwrite_d;
   logic [CNT_W-1:0]   stall_count_q, stall_count_d;
   logic               load_use;

   // EX/MEM load flag is tracked for completeness; nothing downstream reads it.
   logic unused_exmem_memread;
   assign unused_exmem_memread = exmem_memread_q;

   // Hazard detection: forwarding selects, write-through bypass, load-use stall.
   always_comb begin
      forward_sel = '0;
      wb_bypass   = '0;
      load_use    = 1'b0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         // Nearer producer (EX/MEM) wins over the older one (MEM/WB).
         if (idex_use_q[k] && exmem_regwrite_q && (exmem_rd_q != '0) &&
             (exmem_rd_q == idex_rs_q[k*REG_AW +: REG_AW]))
            forward_sel[2*k +: 2] = 2'b10;
         else if (idex_use_q[k] && memwb_regwrite_q && (memwb_rd_q != '0) &&
                  (memwb_rd_q == idex_rs_q[k*REG_AW +: REG_AW]))
            forward_sel[2*k +: 2] = 2'b01;

         if (id_valid && id_use[k] && memwb_regwrite_q && (memwb_rd_q != '0) &&
             (memwb_rd_q == id_rs[k*REG_AW +: REG_AW]))
            wb_bypass[k] = 1'b1;

         if (id_use[k] && (id_rs[k*REG_AW +: REG_AW] == idex_rd_q))
            load_use = 1'b1;
      end
      // Flush wins over a coincident load-use hazard.
      stall = id_valid && !flush && idex_memread_q && (idex_rd_q != '0) && load_use;
   end

   // Shadow pipeline advance and stall statistics.
   always_comb begin
      idex_rs_d        = idex_rs_q;
      idex_use_d       = idex_use_q;
      idex_rd_d        = idex_rd_q;
      idex_regwrite_d  = idex_regwrite_q;
      idex_memread_d   = idex_memread_q;
      exmem_rd_d       = exmem_rd_q;
      exmem_regwrite_d = exmem_regwrite_q;
      exmem_memread_d  = exmem_memread_q;
      memwb_rd_d       = memwb_rd_q;
      memwb_regwrite_d = memwb_regwrite_q;
      stall_count_d    = stall_count_q;
      if (!ext_stall) begin
         memwb_rd_d       = exmem_rd_q;
         memwb_regwrite_d = exmem_regwrite_q;
         exmem_rd_d       = idex_rd_q;
         exmem_regwrite_d = idex_regwrite_q;
         exmem_memread_d  = idex_memread_q;
         if (flush || stall || !id_valid) begin
            idex_rs_d       = '0;
            idex_use_d      = '0;
            idex_rd_d       = '0;
            idex_regwrite_d = 1'b0;
            idex_memread_d  = 1'b0;
         end else begin
            idex_rs_d       = id_rs;
            idex_use_d      = id_use;
            idex_rd_d       = id_rd;
            idex_regwrite_d = id_regwrite;
            idex_memread_d  = id_memread;
         end
         if (stall && (stall_count_q != CNT_MAX))
            stall_count_d = stall_count_q + CNT_W'(1);
      end
   end

   // State registers; reset clears every stage to a bubble.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idex_rs_q        <= '0;
         idex_use_q       <= '0;
         idex_rd_q        <= '0;
         idex_regwrite_q  <= 1'b0;
         idex_memread_q   <= 1'b0;
         exmem_rd_q       <= '0;
         exmem_regwrite_q <= 1'b0;
         exmem_memread_q  <= 1'b0;
         memwb_rd_q       <= '0;
         memwb_regwrite_q <= 1'b0;
         stall_count_q    <= '0;
      end else begin
         idex_rs_q        <= idex_rs_d;
         idex_use_q       <= idex_use_d;
         idex_rd_q        <= idex_rd_d;
         idex_regwrite_q  <= idex_regwrite_d;
         idex_memread_q   <= idex_memread_d;
         exmem_rd_q       <= exmem_rd_d;
         exmem_regwrite_q <= exmem_regwrite_d;
         exmem_memread_q  <= exmem_memread_d;
         memwb_rd_q       <= memwb_rd_d;
         memwb_regwrite_q <= memwb_regwrite_d;
         stall_count_q    <= stall_count_d;
      end
   end

   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Self-checking bench for forwarding_hazard_unit: directed pipeline scenarios
// plus randomized traffic against an instruction-level pipeline model.
module tb_forwarding_hazard_unit;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        id_valid = 1'b0;
   logic [9:0]  id_rs = '0;
   logic [1:0]  id_use = '0;
   logic [4:0]  id_rd = '0;
   logic        id_regwrite = 1'b0;
   logic        id_memread = 1'b0;
   logic        flush = 1'b0;
   logic        ext_stall = 1'b0;
   logic [3:0]  forward_sel, fs2;
   logic [1:0]  wb_bypass, bp2;
   logic        stall, st2;
   logic [15:0] stall_count;
   logic [1:0]  cnt2;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   forwarding_hazard_unit dut (
      .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_use(id_use),
      .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
      .ext_stall(ext_stall), .forward_sel(forward_sel), .wb_bypass(wb_bypass),
      .stall(stall), .stall_count(stall_count));

   forwarding_hazard_unit #(.CNT_W(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_use(id_use),
      .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
      .ext_stall(ext_stall), .forward_sel(fs2), .wb_bypass(bp2),
      .stall(st2), .stall_count(cnt2));

   // Instruction-level model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB; all-zero = bubble.
   typedef struct packed {
      logic [4:0] s1;
      logic [4:0] s0;
      logic [1:0] u;
      logic [4:0] rd;
      logic       rw;
      logic       mr;
   } instr_t;

   instr_t pipe [3];
   int     model_cnt;

   function automatic logic [4:0] src_of(input instr_t i, input int k);
      return (k == 0) ? i.s0 : i.s1;
   endfunction

   function automatic void model_eval(input logic v, input instr_t id, input logic fl,
                                      output logic [3:0] fs, output logic [1:0] bp,
                                      output logic st);
      logic hit;
      fs  = '0;
      bp  = '0;
      hit = 1'b0;
      for (int k = 0; k < 2; k++) begin
         // Search older instructions from youngest to oldest for the value.
         for (int j = 1; j < 3; j++) begin
            if (pipe[0].u[k] && pipe[j].rw && pipe[j].rd != 0 &&
                pipe[j].rd == src_of(pipe[0], k) && fs[2*k +: 2] == 2'b00)
               fs[2*k +: 2] = (j == 1) ? 2'b10 : 2'b01;
         end
         if (v && id.u[k] && pipe[2].rw && pipe[2].rd != 0 && pipe[2].rd == src_of(id, k))
            bp[k] = 1'b1;
         if (id.u[k] && src_of(id, k) == pipe[0].rd) hit = 1'b1;
      end
      st = v && !fl && pipe[0].mr && pipe[0].rd != 0 && hit;
   endfunction

   function automatic void model_commit(input logic v, input instr_t id, input logic fl,
                                        input logic es, input logic st);
      if (es) return;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (fl || st || !v) ? instr_t'(0) : id;
      if (st) model_cnt++;
   endfunction

   // Present one ID-stage slot at the falling edge; outputs settle 1 time unit later.
   task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [1:0] u, input logic [4:0] rd, input logic rw,
                        input logic mr, input logic fl, input logic es);
      @(negedge clk);
      id_valid = v; id_rs = {s1, s0}; id_use = u; id_rd = rd;
      id_regwrite = rw; id_memread = mr; flush = fl; ext_stall = es;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      id_valid = 1'b0; id_rs = '0; id_use = '0; id_rd = '0;
      id_regwrite = 1'b0; id_memread = 1'b0; flush = 1'b0; ext_stall = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      checks++;
      if ({forward_sel, wb_bypass, stall, stall_count} !== 23'd0)
         $display("FAIL reset_outputs got fs=%b bp=%b st=%b cnt=%0d want all zero",
                  forward_sel, wb_bypass, stall, stall_count);
      else passed++;
      checks++;
      if ({fs2, bp2, st2, cnt2} !== 9'd0)
         $display("FAIL reset_outputs_cnt2 got fs=%b bp=%b st=%b cnt=%0d want all zero",
                  fs2, bp2, st2, cnt2);
      else passed++;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_back_to_back();
      do_reset();
      drive(1, 0, 0, 2'b00, 5, 1, 0, 0, 0);           // add x5
      drive(1, 5, 5, 2'b11, 6, 1, 0, 0, 0);           // sub x6, x5, x5
      checks++;
      if (stall !== 1'b0) $display("FAIL b2b_nostall got %b want 0", stall); else passed++;
      idle();
      checks++;
      if (forward_sel !== 4'b1010) $display("FAIL b2b_fwd got %b want 1010", forward_sel);
      else passed++;
      drive(1, 5, 5, 2'b11, 7, 1, 0, 0, 0);           // add x5 now in WB
      checks++;
      if (wb_bypass !== 2'b11) $display("FAIL b2b_wb_bypass got %b want 11", wb_bypass);
      else passed++;
      checks++;
      if (forward_sel !== 4'b0000) $display("FAIL b2b_bubble_fwd got %b want 0000", forward_sel);
      else passed++;
   endtask

   task automatic test_double_hazard();
      do_reset();
      drive(1, 0, 0, 2'b00, 5, 1, 0, 0, 0);
      drive(1, 0, 0, 2'b00, 5, 1, 0, 0, 0);
      drive(1, 5, 0, 2'b01, 8, 1, 0, 0, 0);           // or x8, x5
      idle();
      checks++;
      if (forward_sel !== 4'b0010) $display("FAIL double_fwd got %b want 0010", forward_sel);
      else passed++;
   endtask

   task automatic test_load_use();
      do_reset();
      drive(1, 0, 0, 2'b00, 7, 1, 1, 0, 0);           // lw x7
      drive(1, 3, 7, 2'b11, 9, 1, 0, 0, 0);           // add x9, x3, x7
      checks++;
      if (stall !== 1'b1) $display("FAIL lu_stall got %b want 1", stall); else passed++;
      drive(1, 3, 7, 2'b11, 9, 1, 0, 0, 0);           // held instruction re-presented
      checks++;
      if (stall !== 1'b0 || stall_count !== 16'd1)
         $display("FAIL lu_release got st=%b cnt=%0d want st=0 cnt=1", stall, stall_count);
      else passed++;
      idle();
      checks++;
      if (forward_sel !== 4'b0100) $display("FAIL lu_fwd got %b want 0100", forward_sel);
      else passed++;
   endtask

   task automatic test_flush();
      do_reset();
      drive(1, 0, 0, 2'b00, 7, 1, 1, 0, 0);
      drive(1, 3, 7, 2'b11, 9, 1, 0, 1, 0);           // hazard with flush
      checks++;
      if (stall !== 1'b0) $display("FAIL flush_stall got %b want 0", stall); else passed++;
      idle();
      checks++;
      if (forward_sel !== 4'b0000 || stall_count !== 16'd0)
         $display("FAIL flush_bubble got fs=%b cnt=%0d want fs=0000 cnt=0", forward_sel, stall_count);
      else passed++;
   endtask

   task automatic test_ext_stall();
      do_reset();
      drive(1, 0, 0, 2'b00, 7, 1, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         drive(1, 3, 7, 2'b11, 9, 1, 0, 0, 1);
         checks++;
         if (stall !== 1'b1 || stall_count !== 16'd0)
            $display("FAIL ext_hold_%0d got st=%b cnt=%0d want st=1 cnt=0", i, stall, stall_count);
         else passed++;
      end
      drive(1, 3, 7, 2'b11, 9, 1, 0, 0, 0);
      checks++;
      if (stall !== 1'b1) $display("FAIL ext_release_stall got %b want 1", stall); else passed++;
      drive(1, 3, 7, 2'b11, 9, 1, 0, 0, 0);
      checks++;
      if (stall !== 1'b0 || stall_count !== 16'd1)
         $display("FAIL ext_after got st=%b cnt=%0d want st=0 cnt=1", stall, stall_count);
      else passed++;
      idle();
      checks++;
      if (forward_sel !== 4'b0100) $display("FAIL ext_fwd got %b want 0100", forward_sel);
      else passed++;
   endtask

   task automatic test_saturation_and_x0();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 0, 2'b00, 7, 1, 1, 0, 0);
         drive(1, 3, 7, 2'b11, 9, 1, 0, 0, 0);
         drive(1, 3, 7, 2'b11, 9, 1, 0, 0, 0);
      end
      checks++;
      if (stall_count !== 16'd5 || cnt2 !== 2'd3)
         $display("FAIL sat_count got cnt=%0d cnt2=%0d want 5 and 3", stall_count, cnt2);
      else passed++;
      // Writers and readers of x0 only.
      drive(1, 0, 0, 2'b00, 0, 1, 0, 0, 0);
      drive(1, 0, 0, 2'b11, 0, 1, 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, 2'b11, 5, 1, 0, 0, 0);
         checks++;
         if (forward_sel !== 4'b0000 || stall !== 1'b0 || wb_bypass !== 2'b00)
            $display("FAIL x0_cycle%0d got fs=%b st=%b bp=%b want 0000/0/00",
                     i, forward_sel, stall, wb_bypass);
         else passed++;
      end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      drive(1, 0, 0, 2'b00, 7, 1, 1, 0, 0);
      drive(1, 3, 7, 2'b11, 9, 1, 0, 0, 0);
      drive(1, 3, 7, 2'b11, 9, 1, 0, 0, 0);
      drive(1, 0, 0, 2'b00, 7, 1, 1, 0, 0);
      drive(1, 7, 0, 2'b01, 9, 1, 0, 0, 0);
      checks++;
      if (stall !== 1'b1 || stall_count !== 16'd1)
         $display("FAIL rst_pre got st=%b cnt=%0d want st=1 cnt=1", stall, stall_count);
      else passed++;
      reset_n = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b0 || stall_count !== 16'd0)
         $display("FAIL rst_abort got st=%b cnt=%0d want st=0 cnt=0", stall, stall_count);
      else passed++;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_random();
      logic [3:0] efs;
      logic [1:0] ebp;
      logic       est;
      do_reset();
      for (int j = 0; j < 3; j++) pipe[j] = instr_t'(0);
      model_cnt = 0;
      for (int i = 0; i < 400; i++) begin
         instr_t id;
         logic   v, fl, es;
         v     = ($urandom_range(7) != 0);
         id.s0 = 5'($urandom_range(3));
         id.s1 = 5'($urandom_range(3));
         id.u  = 2'($urandom_range(3));
         id.rd = 5'($urandom_range(3));
         id.mr = ($urandom_range(2) == 0);
         id.rw = id.mr | 1'($urandom_range(1));
         fl    = ($urandom_range(7) == 0);
         es    = ($urandom_range(7) == 0);
         drive(v, id.s0, id.s1, id.u, id.rd, id.rw, id.mr, fl, es);
         model_eval(v, id, fl, efs, ebp, est);
         checks++;
         if ({forward_sel, wb_bypass, stall} !== {efs, ebp, est})
            $display("FAIL rand_%0d_comb got fs=%b bp=%b st=%b want fs=%b bp=%b st=%b",
                     i, forward_sel, wb_bypass, stall, efs, ebp, est);
         else passed++;
         checks++;
         if (stall_count !== 16'(model_cnt))
            $display("FAIL rand_%0d_cnt got %0d want %0d", i, stall_count, model_cnt);
         else passed++;
         checks++;
         if ({fs2, bp2, st2, cnt2} !== {efs, ebp, est, 2'((model_cnt > 3) ? 3 : model_cnt)})
            $display("FAIL rand_%0d_dut2 got fs=%b bp=%b st=%b cnt=%0d want fs=%b bp=%b st=%b cnt=%0d",
                     i, fs2, bp2, st2, cnt2, efs, ebp, est, (model_cnt > 3) ? 3 : model_cnt);
         else passed++;
         model_commit(v, id, fl, es, est);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_double_hazard();
      test_load_use();
      test_flush();
      test_ext_stall();
      test_saturation_and_x0();
      test_reset_mid_stall();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
